// File: rtl/gerador_clock_sap_if.sv
// Operator/SAP-side signal bundle of the SAP-1 clock front end.
// master drives the raw inputs; slave is the clock generator itself.
interface gerador_clock_sap_if #(
    parameter int CNT_W = 8
);
    logic             key0_n;
    logic             prog_run;
    logic             selecao_manual_auto;
    logic             hlt_sig;
    logic             pulso_sap;
    logic             clock_auto;
    logic             key0_limpo;
    logic [1:0]       estado;
    logic [CNT_W-1:0] ciclos;

    modport master (
        output key0_n, prog_run, selecao_manual_auto, hlt_sig,
        input  pulso_sap, clock_auto, key0_limpo, estado, ciclos
    );

    modport slave (
        input  key0_n, prog_run, selecao_manual_auto, hlt_sig,
        output pulso_sap, clock_auto, key0_limpo, estado, ciclos
    );
endinterface

// File: rtl/gerador_clock_sap.sv
// SAP-1 clock front end: input sync/debounce, run/halt FSM, auto divider
// and single-cycle step pulse generation, all in the clock_fpga domain.
//
// state  | meaning
// PARADO | stopped, waiting for the run switch
// AUTO   | free running, one step per clock_auto period
// MANUAL | one step per debounced key press
// HALT   | stopped by HLT, sticky until run switch goes low
module gerador_clock_sap #(
    parameter int DIV_HALF        = 25000000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 8
) (
    input logic                clock_fpga,
    input logic                reset,
    gerador_clock_sap_if.slave sap
);
    localparam int DIV_W = $clog2(DIV_HALF);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV_HALF - 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        PARADO = 2'b00,
        AUTO   = 2'b01,
        MANUAL = 2'b10,
        HALT   = 2'b11
    } estado_t;

    estado_t          state_q, state_d;
    logic [1:0]       key_sync_q, run_sync_q, sel_sync_q;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             key_limpo_q, key_limpo_d;
    logic             key_limpo_ant_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic             clock_auto_q, clock_auto_d;
    logic             pulso_q, pulso_d;
    logic [CNT_W-1:0] ciclos_q, ciclos_d;

    logic key_s, run_s, sel_s;
    logic em_auto, em_manual;

    assign key_s = ~key_sync_q[1];
    assign run_s = run_sync_q[1];
    assign sel_s = sel_sync_q[1];

    // Debounce: the stable level only follows after DEBOUNCE_CYCLES disagreeing edges in a row.
    always_comb begin
        deb_cnt_d   = '0;
        key_limpo_d = key_limpo_q;
        if (key_s != key_limpo_q) begin
            if (deb_cnt_q == DEB_MAX) begin
                key_limpo_d = key_s;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PARADO: begin
                if (run_s) begin
                    state_d = sel_s ? AUTO : MANUAL;
                end
            end
            AUTO, MANUAL: begin
                if (sap.hlt_sig) begin
                    state_d = HALT;
                end else if (!run_s) begin
                    state_d = PARADO;
                end else begin
                    state_d = sel_s ? AUTO : MANUAL;
                end
            end
            HALT: begin
                if (!run_s) begin
                    state_d = PARADO;
                end
            end
            default: state_d = PARADO;
        endcase
    end

    // Stepping requires staying in the mode across the edge: the entry edge
    // restarts the divider and the edge leaving (e.g. into HALT) emits nothing.
    assign em_auto   = (state_q == AUTO)   && (state_d == AUTO);
    assign em_manual = (state_q == MANUAL) && (state_d == MANUAL);

    always_comb begin
        div_d        = '0;
        clock_auto_d = 1'b0;
        pulso_d      = 1'b0;
        if (em_auto) begin
            if (div_q == DIV_MAX) begin
                clock_auto_d = ~clock_auto_q;
                pulso_d      = ~clock_auto_q;
            end else begin
                div_d        = div_q + DIV_W'(1);
                clock_auto_d = clock_auto_q;
            end
        end else if (em_manual) begin
            pulso_d = key_limpo_q & ~key_limpo_ant_q;
        end
    end

    always_comb begin
        ciclos_d = ciclos_q;
        if ((state_q == PARADO) && (state_d != PARADO)) begin
            ciclos_d = '0;
        end else if (pulso_d) begin
            ciclos_d = ciclos_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock_fpga) begin
        if (reset) begin
            key_sync_q      <= 2'b11;
            run_sync_q      <= 2'b00;
            sel_sync_q      <= 2'b00;
            deb_cnt_q       <= '0;
            key_limpo_q     <= 1'b0;
            key_limpo_ant_q <= 1'b0;
            state_q         <= PARADO;
            div_q           <= '0;
            clock_auto_q    <= 1'b0;
            pulso_q         <= 1'b0;
            ciclos_q        <= '0;
        end else begin
            key_sync_q      <= {key_sync_q[0], sap.key0_n};
            run_sync_q      <= {run_sync_q[0], sap.prog_run};
            sel_sync_q      <= {sel_sync_q[0], sap.selecao_manual_auto};
            deb_cnt_q       <= deb_cnt_d;
            key_limpo_q     <= key_limpo_d;
            key_limpo_ant_q <= key_limpo_q;
            state_q         <= state_d;
            div_q           <= div_d;
            clock_auto_q    <= clock_auto_d;
            pulso_q         <= pulso_d;
            ciclos_q        <= ciclos_d;
        end
    end

    assign sap.pulso_sap  = pulso_q;
    assign sap.clock_auto = clock_auto_q;
    assign sap.key0_limpo = key_limpo_q;
    assign sap.estado     = state_q;
    assign sap.ciclos     = ciclos_q;
endmodule

// File: tb/tb_gerador_clock_sap.sv
// Directed bench for gerador_clock_sap with DIV_HALF=4, DEBOUNCE_CYCLES=8.
// Inputs change at the falling edge; outputs are sampled there too.
module tb_gerador_clock_sap;
    localparam int DIV_HALF = 4;
    localparam int DEB      = 8;
    localparam int CNT_W    = 8;
    localparam int NVEC     = 19;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    gerador_clock_sap_if #(.CNT_W(CNT_W)) sap ();

    gerador_clock_sap #(
        .DIV_HALF        (DIV_HALF),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (CNT_W)
    ) dut (
        .clock_fpga (clk),
        .reset      (rst),
        .sap        (sap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       rst;
        logic       key_n;
        logic       run;
        logic       sel;
        logic       hlt;
        logic [1:0] est;
        logic       ca;
        logic       p;
        logic [7:0] cic;
        logic       lim;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_est(input logic [1:0] e, input int maxc, input string nm);
        int n;
        n = 0;
        while (sap.estado !== e && n < maxc) begin
            tick();
            n++;
        end
        check(nm, 32'(sap.estado), 32'(e));
    endtask

    task automatic wait_pulse(input int maxc, input string nm);
        int n;
        n = 0;
        while (sap.pulso_sap !== 1'b1 && n < maxc) begin
            tick();
            n++;
        end
        check(nm, 32'(sap.pulso_sap), 32'd1);
    endtask

    initial begin
        int npulse;
        int pulse_at;
        int lim_at;
        int lim_seen;
        int cyc;
        logic [7:0] c0;
        int glen [3];

        total = 0;
        bad   = 0;
        glen[0] = 3;
        glen[1] = 5;
        glen[2] = 7;

        //            rst   key_n run   sel   hlt   est    ca    p     cic    lim
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 8'd1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 8'd1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 8'd1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 8'd1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 8'd1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 8'd1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 8'd1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 8'd1, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 8'd2, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 8'd2, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 8'd2, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 8'd2, 1'b0};

        // Reset, start in AUTO, two clock_auto periods, then move to MANUAL.
        for (int i = 0; i < NVEC; i++) begin
            rst                     = vecs[i].rst;
            sap.key0_n              = vecs[i].key_n;
            sap.prog_run            = vecs[i].run;
            sap.selecao_manual_auto = vecs[i].sel;
            sap.hlt_sig             = vecs[i].hlt;
            tick();
            check($sformatf("row%0d_estado", i),  32'(sap.estado),     32'(vecs[i].est));
            check($sformatf("row%0d_clkauto", i), 32'(sap.clock_auto), 32'(vecs[i].ca));
            check($sformatf("row%0d_pulso", i),   32'(sap.pulso_sap),  32'(vecs[i].p));
            check($sformatf("row%0d_ciclos", i),  32'(sap.ciclos),     32'(vecs[i].cic));
            check($sformatf("row%0d_limpo", i),   32'(sap.key0_limpo), 32'(vecs[i].lim));
        end

        // Manual press: edge k counts from the first edge that samples key0_n=0.
        sap.key0_n = 1'b0;
        npulse = 0;
        pulse_at = -1;
        lim_at = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (sap.pulso_sap === 1'b1) begin
                npulse++;
                if (pulse_at < 0) pulse_at = k;
            end
            if (sap.key0_limpo === 1'b1 && lim_at < 0) lim_at = k;
        end
        check("press_pulse_count", 32'(npulse), 32'd1);
        check("press_pulse_time", 32'(pulse_at), 32'(DEB + 3));
        check("press_limpo_time", 32'(lim_at), 32'(DEB + 2));
        check("press_ciclos", 32'(sap.ciclos), 32'd3);

        sap.key0_n = 1'b1;
        npulse = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (sap.pulso_sap === 1'b1) npulse++;
        end
        check("release_pulse_count", 32'(npulse), 32'd0);
        check("release_limpo", 32'(sap.key0_limpo), 32'd0);
        check("release_ciclos", 32'(sap.ciclos), 32'd3);

        // Short low glitches must not be accepted.
        npulse = 0;
        lim_seen = 0;
        for (int g = 0; g < 3; g++) begin
            sap.key0_n = 1'b0;
            for (int k = 0; k < glen[g]; k++) begin
                tick();
                if (sap.pulso_sap === 1'b1) npulse++;
                if (sap.key0_limpo === 1'b1) lim_seen++;
            end
            sap.key0_n = 1'b1;
            for (int k = 0; k < 4; k++) begin
                tick();
                if (sap.pulso_sap === 1'b1) npulse++;
                if (sap.key0_limpo === 1'b1) lim_seen++;
            end
        end
        check("glitch_limpo", 32'(lim_seen), 32'd0);
        check("glitch_pulses", 32'(npulse), 32'd0);
        check("glitch_ciclos", 32'(sap.ciclos), 32'd3);

        // HLT lands on the edge where a rising clock_auto would otherwise fire.
        sap.selecao_manual_auto = 1'b1;
        wait_est(2'd1, 10, "to_auto_estado");
        wait_pulse(20, "auto_first_pulse");
        c0 = sap.ciclos;
        for (int k = 0; k < 2 * DIV_HALF - 1; k++) tick();
        sap.hlt_sig = 1'b1;
        tick();
        sap.hlt_sig = 1'b0;
        check("hlt_estado", 32'(sap.estado), 32'd3);
        check("hlt_clkauto", 32'(sap.clock_auto), 32'd0);
        check("hlt_pulso", 32'(sap.pulso_sap), 32'd0);
        check("hlt_ciclos", 32'(sap.ciclos), 32'(c0));
        npulse = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (sap.pulso_sap === 1'b1) npulse++;
        end
        check("halt_sticky_estado", 32'(sap.estado), 32'd3);
        check("halt_pulses", 32'(npulse), 32'd0);
        sap.prog_run = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check("halt_to_parado", 32'(sap.estado), 32'd0);
        check("parado_ciclos_held", 32'(sap.ciclos), 32'(c0));
        sap.prog_run = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        check("restart_estado", 32'(sap.estado), 32'd1);
        check("restart_ciclos", 32'(sap.ciclos), 32'd0);

        // Preload 255 pulses, then the next one wraps ciclos.
        npulse = 0;
        cyc = 0;
        while (sap.ciclos !== 8'd255 && cyc < 3000) begin
            tick();
            cyc++;
            if (sap.pulso_sap === 1'b1) npulse++;
        end
        check("preload_ciclos", 32'(sap.ciclos), 32'd255);
        check("preload_pulses", 32'(npulse), 32'd255);
        tick();
        wait_pulse(20, "wrap_pulse");
        check("wrap_ciclos", 32'(sap.ciclos), 32'd0);

        // Reset in the middle of a half-period.
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rst_auto_estado", 32'(sap.estado), 32'd0);
        check("rst_auto_clkauto", 32'(sap.clock_auto), 32'd0);
        check("rst_auto_pulso", 32'(sap.pulso_sap), 32'd0);
        check("rst_auto_ciclos", 32'(sap.ciclos), 32'd0);
        check("rst_auto_limpo", 32'(sap.key0_limpo), 32'd0);
        sap.prog_run = 1'b0;
        tick();
        rst = 1'b0;
        npulse = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (sap.pulso_sap === 1'b1) npulse++;
        end
        check("post_rst_auto_pulses", 32'(npulse), 32'd0);
        check("post_rst_auto_estado", 32'(sap.estado), 32'd0);

        // Reset while a press is half debounced in MANUAL.
        sap.prog_run = 1'b1;
        sap.selecao_manual_auto = 1'b0;
        wait_est(2'd2, 10, "to_manual_estado");
        sap.key0_n = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        rst = 1'b1;
        tick();
        check("rst_man_estado", 32'(sap.estado), 32'd0);
        check("rst_man_limpo", 32'(sap.key0_limpo), 32'd0);
        check("rst_man_pulso", 32'(sap.pulso_sap), 32'd0);
        check("rst_man_ciclos", 32'(sap.ciclos), 32'd0);
        sap.key0_n = 1'b1;
        sap.prog_run = 1'b0;
        tick();
        rst = 1'b0;
        npulse = 0;
        lim_seen = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (sap.pulso_sap === 1'b1) npulse++;
            if (sap.key0_limpo === 1'b1) lim_seen++;
        end
        check("post_rst_man_pulses", 32'(npulse), 32'd0);
        check("post_rst_man_limpo", 32'(lim_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
